// File: rtl/ef_dac_streamer_pkg.sv
// ef_dac_streamer_pkg: FSM states, AHB-Lite encodings and target-level threshold shared by the streamer.
package ef_dac_streamer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
`ifdef EF_DAC_STREAMER_LEVEL_POLL_EN
    ,
    PADDR,
    PDATA
`endif
  } state_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [4:0] LEVEL_FULL = 5'd16;
endpackage

// File: rtl/ef_dac_streamer_fifo.sv
// ef_dac_streamer_fifo: synchronous sample FIFO; two_o flags at least two entries for write pipelining.
module ef_dac_streamer_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         two_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q] <= data_i;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign data_o = mem_q[rp_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign two_o = cnt_q > (AW+1)'(1);
endmodule

// File: rtl/ef_dac_ahbl_streamer.sv
// ef_dac_ahbl_streamer: streams buffered DAC samples as AHB-Lite word writes to one target register.
// Define EF_DAC_STREAMER_LEVEL_POLL_EN to read the target FIFO level before every write.
module ef_dac_ahbl_streamer
  import ef_dac_streamer_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] LEVEL_OFS = 32'h8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [31:0]       dst_addr,
  input  logic [15:0]       count,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e state_q;
  logic [31:0] addr_q;
  logic [15:0] rem_q;
  logic done_q, err_q, rdy_q;
  logic [DATA_W-1:0] head;
  logic full, empty, two, push, pop, nxt, wr_req, rd_req, unused_rd;
  assign s_ready = rdy_q && !full;
  assign push = s_valid && s_ready;
  assign pop = state_q == DATA && HREADY && !HRESP;
  ef_dac_streamer_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(HCLK), .rst_ni(HRESETn), .push_i(push), .data_i(s_data), .pop_i(pop),
    .data_o(head), .full_o(full), .empty_o(empty), .two_o(two)
  );
`ifdef EF_DAC_STREAMER_LEVEL_POLL_EN
  assign nxt = 1'b0;
  assign rd_req = state_q == PADDR;
  assign HADDR = rd_req ? addr_q + LEVEL_OFS : addr_q;
  assign unused_rd = ^{HRDATA[31:5], two};
`else
  assign nxt = rem_q > 16'd1 && two;
  assign rd_req = 1'b0;
  assign HADDR = addr_q;
  assign unused_rd = ^{HRDATA, LEVEL_OFS};
`endif
  // An error response cancels the pipelined address in its first cycle.
  assign wr_req = (state_q == ADDR && !empty) || (state_q == DATA && nxt && !HRESP);
  assign HTRANS = (wr_req || rd_req) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = wr_req;
  assign HSIZE = HSIZE_WORD;
  assign HWDATA = state_q == DATA ? 32'(head) : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  always_ff @(posedge HCLK)
    if (!HRESETn) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            err_q <= 1'b0;
            addr_q <= dst_addr;
            rem_q <= count;
            if (count == 16'd0) done_q <= 1'b1;
`ifdef EF_DAC_STREAMER_LEVEL_POLL_EN
            else state_q <= PADDR;
`else
            else state_q <= ADDR;
`endif
          end
        ADDR: if (HREADY && !empty) state_q <= DATA;
        DATA:
          if (HRESP) begin
            state_q <= ERR;
            err_q <= 1'b1;
          end else if (HREADY) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= IDLE;
              done_q <= 1'b1;
`ifdef EF_DAC_STREAMER_LEVEL_POLL_EN
            end else if (!nxt) state_q <= PADDR;
`else
            end else if (!nxt) state_q <= ADDR;
`endif
          end
`ifdef EF_DAC_STREAMER_LEVEL_POLL_EN
        PADDR: if (HREADY) state_q <= PDATA;
        PDATA:
          if (HRESP) begin
            state_q <= ERR;
            err_q <= 1'b1;
          end else if (HREADY) state_q <= HRDATA[4:0] >= LEVEL_FULL ? PADDR : ADDR;
`endif
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/ef_dac_ahbl_streamer.md
EF_DAC_AHBL_STREAMER -- requirements
Module: ef_dac_ahbl_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of one DAC sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the sample buffer (power of 2, >=2).
REQ-003 SHALL have parameter LEVEL_OFS, default 32'h8, byte offset from dst_addr of the target FIFO-level register (poll mode only).
REQ-004 SHALL have port HCLK  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port HRESETn  in  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle job start; ignored while busy.
REQ-007 SHALL have port dst_addr  in  32  target DATA register address, latched on accepted start.
REQ-008 SHALL have port count  in  16  samples to write, latched on accepted start.
REQ-009 SHALL have ports s_data  in  DATA_W, s_valid  in  1, s_ready  out  1: sample stream; a transfer occurs when s_valid&s_ready.
REQ-010 SHALL have AHB-Lite manager ports HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HWDATA out 32, HREADY in 1, HRESP in 1, HRDATA in 32.
REQ-011 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky).

Function
REQ-012 SHALL buffer samples in a FIFO_DEPTH-entry FIFO; s_ready = not full; a push while full SHALL NOT occur.
REQ-013 SHALL use FSM states IDLE, ADDR, DATA, ERR (plus PADDR, PDATA in poll mode).
REQ-014 IDLE: on start with count!=0 -> ADDR, busy=1; with count==0 -> done pulses next cycle, busy stays 0.
REQ-015 ADDR: when FIFO non-empty, drive HTRANS=NONSEQ, HWRITE=1, HSIZE=3'b010, HADDR=dst_addr; else HTRANS=IDLE; the address phase completes on HREADY=1.
REQ-016 DATA: HWDATA = zero-extended head sample, held stable until HREADY=1; FIFO pops and remaining decrements on that edge.
REQ-017 Pipelining: during DATA, if remaining>1 and a second sample is buffered, SHALL present the next NONSEQ address concurrently, giving one write per cycle at HREADY=1.
REQ-018 On the last write's data phase completing with HREADY=1 SHALL return to IDLE, busy=0, and pulse done exactly one cycle.
REQ-019 HRESP=1 with HREADY=0 (first error cycle): SHALL drive HTRANS=IDLE that cycle (cancelling any pipelined address), enter ERR, set err=1, abort the job without done; queued samples are left in the FIFO.
REQ-020 ERR -> IDLE after one cycle; err clears only on the next accepted start.
REQ-021 HTRANS SHALL never be BUSY or SEQ; HADDR/HWRITE/HSIZE SHALL stay stable while HREADY=0.
REQ-022 remaining counter is 16 bits and SHALL never underflow; count=16'hFFFF SHALL write 65535 samples.

Reset
REQ-023 On HRESETn=0 at a clock edge: state=IDLE, FIFO empty, s_ready=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, busy=0, done=0, err=0; s_ready rises the cycle after release.
REQ-024 Reset mid-job SHALL abandon the transfer with no further bus activity.

Configuration
REQ-025 Macro EF_DAC_STREAMER_LEVEL_POLL_EN: when defined, before each write SHALL do a single read (PADDR/PDATA) of dst_addr+LEVEL_OFS and retry the read while HRDATA[4:0] >= 5'd16 (target FIFO full); REQ-017 pipelining disabled; HRESP on a read handled per REQ-019.
REQ-026 Without the macro: no reads issued, HWRITE=1 on every NONSEQ, PADDR/PDATA absent.

Structure
REQ-027 Shared package ef_dac_streamer_pkg SHALL hold the FSM state enum, HTRANS/HSIZE constants, and the level-full threshold 5'd16.
REQ-028 Sample buffer SHALL be sub-module ef_dac_streamer_fifo (sync FIFO, push/pop/full/empty); the FSM and bus logic remain in the top.

Verification
REQ-029 count=3, dst_addr=0x0, samples 1,2,3 pre-buffered, HREADY=1 -> three NONSEQ writes on consecutive cycles, HWDATA 1,2,3, done one cycle after last data phase.
REQ-030 count=2, HREADY low 3 cycles during first data phase -> HWDATA=1 and next address held stable 3 cycles, then HWDATA=2, done once.
REQ-031 count=4, s_valid asserted 1 cycle of every 5 -> HTRANS=IDLE between writes, exactly 4 writes, remaining never below 0.
REQ-032 count=5, HRESP=1 on 2nd data phase -> HTRANS=IDLE in first error cycle, err=1, no done, no 3rd write; new start clears err.
REQ-033 HRESETn=0 mid-job after 1 write -> all outputs at reset values next cycle, no bus activity until a new start.
REQ-034 With EF_DAC_STREAMER_LEVEL_POLL_EN, HRDATA level=16 twice then 7 -> three reads of 0x8, then one write of 0x0.
